// File: rtl/hamming_rx_deserializer_pkg.sv
// Shared Hamming(7,4) definitions: codeword geometry, bit positions and
// receive-deserializer FSM states.
package hamming_rx_deserializer_pkg;

    localparam int unsigned HAM_CW_W   = 7;
    localparam int unsigned HAM_DATA_W = 4;

    // Code position i+1 lives at h_word[i]: {D7,D6,D5,P4,D3,P2,P1}
    localparam int unsigned P1 = 0;
    localparam int unsigned P2 = 1;
    localparam int unsigned D3 = 2;
    localparam int unsigned P4 = 3;
    localparam int unsigned D5 = 4;
    localparam int unsigned D6 = 5;
    localparam int unsigned D7 = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/hamming_rx_deserializer.sv
// Serial-to-parallel framer for Hamming(7,4) codewords with a one-entry
// valid/ready output register. Received bits pass through uncorrected.
module hamming_rx_deserializer
    import hamming_rx_deserializer_pkg::*;
#(
    parameter int unsigned CW_W      = HAM_CW_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bit_in,
    input  logic            bit_valid,
    input  logic            sof,
    output logic [CW_W-1:0] h_word,
    output logic            h_valid,
    input  logic            h_ready,
    output logic            overrun,
    output logic            frame_err
);

    localparam int unsigned     CNT_W = $clog2(CW_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CW_W - 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [CW_W-1:0]   shreg;
    logic [CW_W-1:0]   first_word;
    logic [CW_W-1:0]   next_shreg;
    logic              start;
    logic              shift;
    logic              out_free;

    // MSB-first shifts left so bit 0 ends up at the top; LSB-first shifts right.
    always_comb begin
        first_word = '0;
        next_shreg = '0;
        if (MSB_FIRST) begin
            first_word = {{(CW_W-1){1'b0}}, bit_in};
            next_shreg = {shreg[CW_W-2:0], bit_in};
        end else begin
            first_word = {bit_in, {(CW_W-1){1'b0}}};
            next_shreg = {bit_in, shreg[CW_W-1:1]};
        end
    end

    assign start    = bit_valid && sof;
    assign shift    = bit_valid && !sof;
    assign out_free = !h_valid || h_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            h_word    <= '0;
            h_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            // A completion below overrides this drop when both occur together.
            if (h_valid && h_ready)
                h_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= first_word;
                        cnt   <= CNT_W'(1);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (start) begin
                        frame_err <= 1'b1;
                        shreg     <= first_word;
                        cnt       <= CNT_W'(1);
                    end else if (shift) begin
                        shreg <= next_shreg;
                        if (cnt == LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            if (out_free) begin
                                h_word  <= next_shreg;
                                h_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// Self-checking bench for hamming_rx_deserializer: directed frame table,
// hand-written corner sequences and random traffic against a queue model.
module tb_hamming_rx_deserializer;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       sof;
    logic [6:0] h_word;
    logic       h_valid;
    logic       h_ready;
    logic       overrun;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bits of the frame in progress, plus the output slot.
    bit       frame_q[$];
    bit       m_valid;
    bit [6:0] m_word;
    bit       m_ovr;
    bit       m_ferr;

    typedef struct {
        string    name;
        bit [6:0] frame;
        bit       gaps;
        bit [6:0] expw;
    } vec_t;

    vec_t vecs[6];

    hamming_rx_deserializer #(.CW_W(7), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .h_word    (h_word),
        .h_valid   (h_valid),
        .h_ready   (h_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One edge of the model, using the inputs currently driven.
    task automatic model_step();
        bit load;
        load   = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        if (bit_valid) begin
            if (sof) begin
                if (frame_q.size() != 0) m_ferr = 1'b1;
                frame_q.delete();
                frame_q.push_back(bit_in);
            end else if (frame_q.size() != 0) begin
                frame_q.push_back(bit_in);
                if (frame_q.size() == 7) begin
                    if (!m_valid || h_ready) begin
                        for (int unsigned i = 0; i < 7; i++) m_word[6-i] = frame_q[i];
                        load = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    frame_q.delete();
                end
            end
        end
        if (load) m_valid = 1'b1;
        else if (m_valid && h_ready) m_valid = 1'b0;
    endtask

    task automatic cyc(input bit bv, input bit b, input bit s, input bit r);
        bit_valid = bv;
        bit_in    = b;
        sof       = s;
        h_ready   = r;
        @(posedge clk);
        model_step();
        #1;
        check("model_h_valid",   h_valid,   m_valid);
        check("model_h_word",    h_word,    m_word);
        check("model_overrun",   overrun,   m_ovr);
        check("model_frame_err", frame_err, m_ferr);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        sof       = 1'b0;
        h_ready   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame_q.delete();
        m_valid = 1'b0;
        m_word  = '0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        check("reset_h_valid",   h_valid,   1'b0);
        check("reset_h_word",    h_word,    7'd0);
        check("reset_overrun",   overrun,   1'b0);
        check("reset_frame_err", frame_err, 1'b0);
    endtask

    task automatic send_frame(input bit [6:0] w, input bit gaps, input bit r);
        for (int unsigned i = 0; i < 7; i++) begin
            if (gaps && i > 0) cyc(1'b0, 1'b0, 1'b0, r);
            cyc(1'b1, w[6-i], i == 0, r);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        sof       = 1'b0;
        h_ready   = 1'b0;

        vecs[0] = '{"basic_0000111",  7'b0000111, 1'b0, 7'b0000111};
        vecs[1] = '{"d5_err_0010111", 7'b0010111, 1'b0, 7'b0010111};
        vecs[2] = '{"gapped_0000001", 7'b0000001, 1'b1, 7'b0000001};
        vecs[3] = '{"gapped_1100000", 7'b1100000, 1'b1, 7'b1100000};
        vecs[4] = '{"all_ones",       7'b1111111, 1'b0, 7'b1111111};
        vecs[5] = '{"alt_1010101",    7'b1010101, 1'b1, 7'b1010101};

        do_reset();

        // Directed table: word visible with h_valid one cycle after the 7th bit.
        foreach (vecs[k]) begin
            send_frame(vecs[k].frame, vecs[k].gaps, 1'b1);
            check({vecs[k].name, "_valid"}, h_valid, 1'b1);
            check({vecs[k].name, "_word"},  h_word,  vecs[k].expw);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            check({vecs[k].name, "_drop"},  h_valid, 1'b0);
        end

        // Overrun: output held full while a second frame completes.
        send_frame(7'b0000111, 1'b0, 1'b0);
        send_frame(7'b1000111, 1'b0, 1'b0);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_word_held", h_word, 7'b0000111);
        check("ovr_still_valid", h_valid, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_one_cycle", overrun, 1'b0);
        check("ovr_stable_word", h_word, 7'b0000111);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_ready_drop", h_valid, 1'b0);

        // Mid-frame sof: partial word discarded, new frame restarts.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("ferr_none_yet", frame_err, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("ferr_pulse", frame_err, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("ferr_one_cycle", frame_err, 1'b0);
        for (int unsigned i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("ferr_valid", h_valid, 1'b1);
        check("ferr_word", h_word, 7'b1100000);

        // Back-to-back frames, sof right after the completing bit.
        send_frame(7'b0110011, 1'b0, 1'b1);
        check("b2b_first", h_word, 7'b0110011);
        send_frame(7'b1001100, 1'b0, 1'b1);
        check("b2b_second", h_word, 7'b1001100);
        check("b2b_valid", h_valid, 1'b1);

        // Reset mid-frame with a held word, then IDLE ignores sof-less bits.
        send_frame(7'b1110000, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 5; i++) cyc(1'b1, i[0], i == 0, 1'b0);
        do_reset();
        for (int unsigned i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("idle_no_sof", h_valid, 1'b0);
        send_frame(7'b0000111, 1'b0, 1'b0);
        check("post_rst_valid", h_valid, 1'b1);
        check("post_rst_word", h_word, 7'b0000111);

        // Random traffic against the model.
        for (int unsigned n = 0; n < 4000; n++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
